// File: rtl/counter_pkg.sv
// counter_pkg
//   Shared definitions for the synchronous down counter slice:
//   the control-state enum and the default counter width.
package counter_pkg;

  // Default counter and load-value width in bits.
  localparam int DEFAULT_WIDTH = 3;

  // IDLE: the count holds. RUN: the count decrements on enabled cycles.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/sync_down_counter_tff_cell.sv
// tff_cell
//   One counter bit built as a T flip-flop with a parallel-load input.
//   The parallel load takes priority over the toggle.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset, clears q
//   t     - toggle enable
//   ld    - parallel-load strobe
//   d     - parallel-load data bit
//   q     - stored bit
module tff_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic t,
  input  logic ld,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (ld) begin
      q <= d;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/sync_down_counter.sv
// sync_down_counter
//   Synchronous, loadable down counter. It produces a one-cycle
//   terminal-count pulse and can optionally reload from the last loaded
//   value. Every bit is clocked by clk, so tc is glitch-free and suitable
//   as a period tick for downstream blocks.
// Parameters:
//   WIDTH       - counter and load-value width
//   AUTO_RELOAD - 1: reload from the stored value after reaching zero
//                 0: one-shot, stop at zero
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   en    - count enable (gates decrement and reload only)
//   load  - synchronous load strobe, captures d (beats en)
//   d     - load value
//   q     - current count, registered
//   tc    - terminal-count pulse, registered, one cycle wide
//   busy  - high while counting (state RUN)
module sync_down_counter
  import counter_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter bit AUTO_RELOAD = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] r_reg, r_next;
  logic             tc_reg, tc_next;

  // Per-cycle controls for the bit cells.
  logic             dec;     // decrement this cycle
  logic             ld;      // parallel load this cycle (load or reload)
  logic [WIDTH-1:0] ld_val;  // value for the parallel load
  logic [WIDTH-1:0] borrow;  // borrow[i]: all bits below i are zero
  logic [WIDTH-1:0] toggle;

  // Next-state and cell controls. The Q=0 case in RUN is handled by an
  // explicit reload (or stop), so the decrement never wraps.
  always_comb begin
    state_next = state_reg;
    r_next     = r_reg;
    tc_next    = 1'b0;
    dec        = 1'b0;
    ld         = 1'b0;
    ld_val     = d;

    if (load) begin
      ld         = 1'b1;
      ld_val     = d;
      r_next     = d;
      state_next = (d != '0) ? RUN : IDLE;
    end else if (state_reg == RUN && en) begin
      if (q > WIDTH'(1)) begin
        dec = 1'b1;
      end else if (q == WIDTH'(1)) begin
        dec     = 1'b1;
        tc_next = 1'b1;
        if (!AUTO_RELOAD) begin
          state_next = IDLE;
        end
      end else begin
        if (AUTO_RELOAD) begin
          ld     = 1'b1;
          ld_val = r_reg;
        end else begin
          state_next = IDLE;
        end
      end
    end
  end

  // Synchronous borrow chain: bit 0 always toggles on a decrement, and
  // bit i toggles only when every lower bit is zero.
  assign borrow[0] = 1'b1;

  generate
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_borrow
      assign borrow[gi] = borrow[gi-1] & ~q[gi-1];
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign toggle[gi] = dec & borrow[gi];

      tff_cell u_cell (
        .clk   (clk),
        .rst_n (rst_n),
        .t     (toggle[gi]),
        .ld    (ld),
        .d     (ld_val[gi]),
        .q     (q[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      r_reg     <= '0;
      tc_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      r_reg     <= r_next;
      tc_reg    <= tc_next;
    end
  end

  assign tc   = tc_reg;
  assign busy = (state_reg == RUN);

endmodule

// File: tb/tb_sync_down_counter.sv
// tb_sync_down_counter
//   Drives a one-shot and an auto-reload instance with the same stimulus.
//   A behavioural model pushes expected outputs into a queue when inputs
//   are applied; each test pops and compares after the clock edge, and
//   also checks hand-derived sequences for the instance it targets.
module tb_sync_down_counter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       load;
  logic [2:0] d;
  logic [2:0] q_os, q_ar;
  logic       tc_os, tc_ar;
  logic       busy_os, busy_ar;

  int errors = 0;
  int checks = 0;

  // Expected {q_os, tc_os, busy_os, q_ar, tc_ar, busy_ar}.
  logic [9:0] sb[$];
  logic [9:0] obs;

  // Behavioural model, index 0 = one-shot, 1 = auto-reload.
  logic [2:0] m_q   [2];
  logic [2:0] m_r   [2];
  logic       m_tc  [2];
  logic       m_run [2];

  assign obs = {q_os, tc_os, busy_os, q_ar, tc_ar, busy_ar};

  sync_down_counter #(.WIDTH(3), .AUTO_RELOAD(1'b0)) dut_os (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .load  (load),
    .d     (d),
    .q     (q_os),
    .tc    (tc_os),
    .busy  (busy_os)
  );

  sync_down_counter #(.WIDTH(3), .AUTO_RELOAD(1'b1)) dut_ar (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .load  (load),
    .d     (d),
    .q     (q_ar),
    .tc    (tc_ar),
    .busy  (busy_ar)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    for (int v = 0; v < 2; v++) begin
      m_q[v] = 3'd0; m_r[v] = 3'd0; m_tc[v] = 1'b0; m_run[v] = 1'b0;
    end
  endtask

  // Apply inputs for the next edge and queue the expected result.
  task automatic apply(input logic e, input logic l, input logic [2:0] dv);
    en = e; load = l; d = dv;
    for (int v = 0; v < 2; v++) begin
      if (l) begin
        m_q[v] = dv; m_r[v] = dv; m_run[v] = (dv != 3'd0); m_tc[v] = 1'b0;
      end else begin
        m_tc[v] = 1'b0;
        if (m_run[v] && e) begin
          if (m_q[v] >= 3'd2) begin
            m_q[v] = m_q[v] - 3'd1;
          end else if (m_q[v] == 3'd1) begin
            m_q[v] = 3'd0; m_tc[v] = 1'b1;
            if (v == 0) m_run[v] = 1'b0;
          end else if (v == 1) begin
            m_q[v] = m_r[v];
          end
        end
      end
    end
    sb.push_back({m_q[0], m_tc[0], m_run[0], m_q[1], m_tc[1], m_run[1]});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [9:0] e;
    rst_n = 1'b0; en = 1'b0; load = 1'b0; d = 3'd0;
    model_reset();
    #2;
    e = {m_q[0], m_tc[0], m_run[0], m_q[1], m_tc[1], m_run[1]};
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_state: got %b want %b", obs, e);
    end
    #1 rst_n = 1'b1;
    $display("reset: outputs %b", obs);
  endtask

  task automatic test_async_reset();
    logic [9:0] e;
    int exp_q[3] = '{5, 4, 3};
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, i == 0, 3'd5);
      tick();
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL async_pre cyc%0d: got %b want %b", i, obs, e);
      end
      checks++;
      if (q_os !== 3'(exp_q[i]) || q_ar !== 3'(exp_q[i])) begin
        errors++;
        $display("FAIL async_pre_q cyc%0d: got %0d/%0d want %0d", i, q_os, q_ar, exp_q[i]);
      end
      $display("async_reset cyc%0d: q_os=%0d q_ar=%0d", i, q_os, q_ar);
    end
    // Reset between edges must clear everything without waiting for clk.
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs !== 10'b0) begin
      errors++;
      $display("FAIL async_immediate: got %b want %b", obs, 10'b0);
    end
    $display("async_reset mid-cycle: outputs %b", obs);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 1'b0, 3'd0);
      tick();
      e = sb.pop_front();
      checks++;
      if (obs !== e || q_os !== 3'd0 || busy_ar !== 1'b0) begin
        errors++;
        $display("FAIL async_post cyc%0d: got %b want %b", i, obs, e);
      end
      $display("async_reset post cyc%0d: outputs %b", i, obs);
    end
  endtask

  task automatic test_one_shot();
    logic [9:0] e;
    int exp_q[8]  = '{3, 2, 1, 0, 0, 0, 0, 0};
    int exp_tc[8] = '{0, 0, 0, 1, 0, 0, 0, 0};
    int exp_bz[8] = '{1, 1, 1, 0, 0, 0, 0, 0};
    for (int i = 0; i < 8; i++) begin
      apply(1'b1, i == 0, 3'd3);
      tick();
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL one_shot cyc%0d: got %b want %b", i, obs, e);
      end
      checks++;
      if (q_os !== 3'(exp_q[i]) || tc_os !== 1'(exp_tc[i]) || busy_os !== 1'(exp_bz[i])) begin
        errors++;
        $display("FAIL one_shot_seq cyc%0d: got q=%0d tc=%b busy=%b want q=%0d tc=%0d busy=%0d",
                 i, q_os, tc_os, busy_os, exp_q[i], exp_tc[i], exp_bz[i]);
      end
      $display("one_shot cyc%0d: q=%0d tc=%b busy=%b", i, q_os, tc_os, busy_os);
    end
  endtask

  task automatic test_auto_reload();
    logic [9:0] e;
    int exp_q[7]  = '{2, 1, 0, 2, 1, 0, 2};
    int exp_tc[7] = '{0, 0, 1, 0, 0, 1, 0};
    for (int i = 0; i < 7; i++) begin
      apply(1'b1, i == 0, 3'd2);
      tick();
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL auto_reload cyc%0d: got %b want %b", i, obs, e);
      end
      checks++;
      if (q_ar !== 3'(exp_q[i]) || tc_ar !== 1'(exp_tc[i]) || busy_ar !== 1'b1) begin
        errors++;
        $display("FAIL auto_reload_seq cyc%0d: got q=%0d tc=%b busy=%b want q=%0d tc=%0d busy=1",
                 i, q_ar, tc_ar, busy_ar, exp_q[i], exp_tc[i]);
      end
      $display("auto_reload cyc%0d: q=%0d tc=%b", i, q_ar, tc_ar);
    end
  endtask

  task automatic test_enable_gating();
    logic [9:0] e;
    int en_pat[9] = '{1, 1, 0, 1, 0, 1, 1, 0, 0};
    int exp_q[9]  = '{4, 3, 3, 2, 2, 1, 0, 0, 0};
    int exp_tc[9] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
    for (int i = 0; i < 9; i++) begin
      apply(1'(en_pat[i]), i == 0, 3'd4);
      tick();
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL enable_gating cyc%0d: got %b want %b", i, obs, e);
      end
      checks++;
      if (q_os !== 3'(exp_q[i]) || q_ar !== 3'(exp_q[i]) ||
          tc_os !== 1'(exp_tc[i]) || tc_ar !== 1'(exp_tc[i])) begin
        errors++;
        $display("FAIL enable_gating_seq cyc%0d: got q=%0d/%0d tc=%b/%b want q=%0d tc=%0d",
                 i, q_os, q_ar, tc_os, tc_ar, exp_q[i], exp_tc[i]);
      end
      $display("enable_gating cyc%0d: en=%0d q=%0d tc=%b", i, en_pat[i], q_os, tc_os);
    end
  endtask

  task automatic test_load_priority();
    logic [9:0] e;
    int ld_pat[6] = '{1, 0, 1, 1, 0, 0};
    int d_pat[6]  = '{2, 0, 7, 0, 0, 0};
    int exp_q[6]  = '{2, 1, 7, 0, 0, 0};
    int exp_bz[6] = '{1, 1, 1, 0, 0, 0};
    for (int i = 0; i < 6; i++) begin
      apply(1'b1, 1'(ld_pat[i]), 3'(d_pat[i]));
      tick();
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL load_priority cyc%0d: got %b want %b", i, obs, e);
      end
      checks++;
      if (q_os !== 3'(exp_q[i]) || q_ar !== 3'(exp_q[i]) || tc_os !== 1'b0 || tc_ar !== 1'b0 ||
          busy_os !== 1'(exp_bz[i]) || busy_ar !== 1'(exp_bz[i])) begin
        errors++;
        $display("FAIL load_priority_seq cyc%0d: got %b want q=%0d tc=0 busy=%0d",
                 i, obs, exp_q[i], exp_bz[i]);
      end
      $display("load_priority cyc%0d: load=%0d d=%0d q=%0d tc=%b", i, ld_pat[i], d_pat[i], q_os, tc_os);
    end
  endtask

  task automatic test_full_range();
    logic [9:0] e;
    int exp_q[10] = '{7, 6, 5, 4, 3, 2, 1, 0, 7, 6};
    for (int i = 0; i < 10; i++) begin
      apply(1'b1, i == 0, 3'd7);
      tick();
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL full_range cyc%0d: got %b want %b", i, obs, e);
      end
      checks++;
      if (q_ar !== 3'(exp_q[i]) || tc_ar !== (i == 7)) begin
        errors++;
        $display("FAIL full_range_seq cyc%0d: got q=%0d tc=%b want q=%0d tc=%0d",
                 i, q_ar, tc_ar, exp_q[i], (i == 7));
      end
      $display("full_range cyc%0d: q=%0d tc=%b", i, q_ar, tc_ar);
    end
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_one_shot();
    test_auto_reload();
    test_enable_gating();
    test_load_priority();
    test_full_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_down_counter.md
# sync_down_counter

Synchronous, loadable, parameterized down counter with terminal-count pulse and optional auto-reload. Complements the lab's 3-bit ripple up counter: it counts the other direction and avoids a rippled clock, because every bit is clocked by the single system clock. It serves as the timing/period generator for downstream lab blocks, such as display multiplexing and blink rate, that need a glitch-free, single-clock terminal-count event.

## Interface
- WIDTH, 3, counter and load-value width in bits.
- AUTO_RELOAD, 1, 1 = reload from stored value on terminal count; 0 = one-shot, stop at zero.

- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- En  input  1  count enable; gates decrement and reload only.
- Load  input  1  synchronous load strobe; captures D.
- D  input  WIDTH  load value.
- Q  output  WIDTH  current count, registered.
- TC  output  1  terminal-count pulse, registered, one Clk cycle wide.
- Busy  output  1  high while the state is RUN.

## Operation
- States:
  - IDLE: no counting.
  - RUN: counting.
- Reset low (async) forces:
  - Q=0, reload register R=0, TC=0, Busy=0, state IDLE.
  - Takes effect immediately, including mid-count.
- Load priority: Load beats En every cycle, in any state.
- Load=1, D≠0: Q←D, R←D, state←RUN, TC←0.
  - A pending terminal count is cancelled.
- Load=1, D=0: Q←0, R←0, state←IDLE, TC←0.
- RUN, En=1, Q>1: Q←Q−1.
- RUN, En=1, Q=1: Q←0, TC←1.
  - AUTO_RELOAD=0: state←IDLE on the same edge.
- RUN, En=1, Q=0 (AUTO_RELOAD=1 only): Q←R, TC←0, stay RUN.
  - Period is R+1 enabled cycles.
- En=0: Q, R and state hold.
- TC rules:
  - TC is high only in the cycle immediately after the Q=1 decrement edge.
  - TC clears on the next edge regardless of En.
  - TC is never asserted by Load or by Reset.
- IDLE with En=1: no change. Q holds its last value, which is 0 after a one-shot completes.
- Arithmetic: unsigned modulo 2^WIDTH. Q never underflows, because the Q=0 cases are handled explicitly.
- Maximum load value: 2^WIDTH−1, which is 7 at the default width.

## Timing
- All outputs are registered; there are no combinational input→output paths.
- Load latency: Q=D is visible one cycle after the Load edge, and Busy updates on the same edge.
- TC timing: TC rises on the same edge on which Q becomes 0.
- One-shot: Busy falls on that same edge, so TC=1 with Busy=0 is legal for one cycle.
- Auto-reload: with En held high, TC pulses once every R+1 cycles.
- Reset deassertion is synchronized externally. The first active edge after release sees state IDLE.

## Structure
- Package counter_pkg holds:
  - the state enum (IDLE, RUN);
  - the default WIDTH constant.
- Sub-module tff_cell: one T flip-flop bit with async active-low reset, toggle enable and parallel load.
  - Instantiated WIDTH times via generate.
  - Bit i toggles when decrementing and all lower bits are 0 (synchronous borrow chain).
  - Its parallel-load port serves both Load and reload.
- Top level contains:
  - the FSM;
  - the reload register R;
  - the TC register;
  - the borrow/toggle-enable chain.

## Test plan
- Async reset mid-count: Load D=5, En=1 for 2 cycles (Q=3), drop Reset between edges → Q=0, TC=0, Busy=0 immediately. After release, Q stays 0 with En=1.
- One-shot, AUTO_RELOAD=0: Load D=3, En held → Q sequence 3,2,1,0. TC=1 only in the Q=0 cycle, Busy falls on that edge, and Q stays 0 for ≥4 further cycles with no further TC.
- Auto-reload, AUTO_RELOAD=1: Load D=2, En held → Q sequence 2,1,0,2,1,0,2. TC pulses exactly every 3 cycles, one cycle wide.
- Enable gating: Load D=4, En pattern 1,0,1,0,1 → Q sequence 4,3,3,2,2,1. TC does not stretch when En=0 in its cycle: Q=1, En=1 then En=0 → TC high exactly one cycle.
- Load priority/cancel:
  - Q=1, En=1 and Load=1 D=7 on the same edge → Q=7, TC=0.
  - Then Load D=0 → Q=0, Busy=0, TC=0.
- Full range, WIDTH=3: Load D=7, auto-reload, En held → Q sequence 7..0,7. Period 8 cycles, no wrap to 7 without the Q=0 cycle, TC once per period.
